pcpi_approx_mul: RTL

PCPI_APPROX_MUL -- requirements
Module: pcpi_approx_mul

---
 rtl/pcpi_approx_pkg.sv | 16 +
 rtl/approx_mul_datapath.sv | 55 +++++
 rtl/pcpi_approx_mul.sv | 73 +++++++
 3 files changed

// File: rtl/pcpi_approx_pkg.sv
// pcpi_approx_pkg: instruction encoding and FSM state constants for the approximate PCPI multiplier.
package pcpi_approx_pkg;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] FUNCT7_MULA = 7'b0000001;
    localparam logic [2:0] F3_MULA     = 3'b000;
    localparam logic [2:0] F3_MULAH    = 3'b001;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic insn_match(input logic [31:0] insn);
        return insn[6:0] == OPC_CUSTOM0 && insn[31:25] == FUNCT7_MULA &&
               (insn[14:12] == F3_MULA || insn[14:12] == F3_MULAH);
    endfunction
endpackage

// File: rtl/approx_mul_datapath.sv
// approx_mul_datapath: serial radix-2 shift-add multiplier over the unmasked high operand bits.
module approx_mul_datapath #(
    parameter int APPROX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        last_o,
    output logic [63:0] prod_o
);
    localparam logic [5:0] K = 6'(32 - APPROX_BITS);

    logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;

    // Masked low bits contribute nothing, so the multiplicand starts pre-shifted past them.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {32'b0, a_i} << APPROX_BITS;
            mplier_d = b_i >> APPROX_BITS;
            cnt_d    = K;
        end else if (step_i) begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last_o = cnt_q == 6'd1;
    assign prod_o = acc_q;
endmodule

// File: rtl/pcpi_approx_mul.sv
// pcpi_approx_mul: PCPI coprocessor computing unsigned products of operands with low bits truncated.
module pcpi_approx_mul
    import pcpi_approx_pkg::*;
#(
    parameter int APPROX_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);
    localparam logic [31:0] MASK = 32'hFFFF_FFFF << APPROX_BITS;

    logic [1:0]  state_q, state_d;
    logic        hi_q, hi_d, wait_q;
    logic        start, step, last;
    logic [63:0] prod;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        start   = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (pcpi_valid && insn_match(pcpi_insn)) begin
                start   = 1'b1;
                hi_d    = pcpi_insn[12];
                state_d = CALC;
            end
            // A dropped valid means the CPU gave up on the instruction.
            CALC: if (!pcpi_valid) state_d = IDLE;
                  else begin
                      step    = 1'b1;
                      state_d = last ? DONE : CALC;
                  end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            wait_q  <= state_d == CALC;
        end
    end

    approx_mul_datapath #(.APPROX_BITS(APPROX_BITS)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .step_i  (step),
        .a_i     (pcpi_rs1 & MASK),
        .b_i     (pcpi_rs2 & MASK),
        .last_o  (last),
        .prod_o  (prod)
    );

    assign pcpi_ready = state_q == DONE;
    assign pcpi_wr    = pcpi_ready;
    assign pcpi_wait  = wait_q;
    assign pcpi_rd    = pcpi_ready ? (hi_q ? prod[63:32] : prod[31:0]) : 32'h0;
endmodule
